// File: rtl/run_ctrl_pkg.sv
// +----------------------------------------------------------------+
// | run_ctrl_pkg : shared state encoding and defaults              |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

package run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      STEP = 2'b10,
      HALT = 2'b11
   } state_t;

   localparam int c_debounce_default = 4;
   localparam int c_cnt_w_default    = 16;

   // Bit positions of the buttons in the packed raw/press vectors.
   localparam int c_btn_run  = 0;
   localparam int c_btn_step = 1;
   localparam int c_btn_stop = 2;
   localparam int c_num_btn  = 3;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// +----------------------------------------------------------------+
// | button_debounce : synchronizer, debounce filter, press pulse   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module button_debounce
   import run_ctrl_pkg::*;
#(
   parameter int DEBOUNCE = c_debounce_default
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int c_cnt_w = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   logic               r_sync1;
   logic               r_sync2;
   logic               r_filt;
   logic               r_filt_d;
   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
      end
   end

   // Counter holds how many consecutive cycles sync has disagreed with
   // the filtered level; the DEBOUNCE-th disagreeing cycle flips it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_filt <= 1'b0;
         r_cnt  <= '0;
      end else if (r_sync2 == r_filt) begin
         r_cnt  <= '0;
      end else if (r_cnt == c_cnt_w'(DEBOUNCE - 1)) begin
         r_filt <= r_sync2;
         r_cnt  <= '0;
      end else begin
         r_cnt  <= r_cnt + c_cnt_w'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_filt_d <= 1'b0;
      end else begin
         r_filt_d <= r_filt;
      end
   end

   assign press = r_filt & ~r_filt_d;

endmodule

`default_nettype wire

// File: rtl/run_controller.sv
// +----------------------------------------------------------------+
// | run_controller : front-panel run/step/stop/halt sequencer      |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int DEBOUNCE = c_debounce_default,
   parameter int CNT_W    = c_cnt_w_default
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_btn,
   input  logic             step_btn,
   input  logic             stop_btn,
   input  logic             instr_done,
   input  logic             halt_in,
   output logic             cpu_en,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] instr_count
);

   logic [c_num_btn-1:0] w_raw;
   logic [c_num_btn-1:0] w_press;
   logic                 w_run_press;
   logic                 w_step_press;
   logic                 w_stop_press;

   state_t               r_state;
   state_t               w_next_state;
   logic [CNT_W-1:0]     r_count;

   assign w_raw[c_btn_run]  = run_btn;
   assign w_raw[c_btn_step] = step_btn;
   assign w_raw[c_btn_stop] = stop_btn;

   generate
      for (genvar gi = 0; gi < c_num_btn; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE (DEBOUNCE)
         ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (w_raw[gi]),
            .press (w_press[gi])
         );
      end
   endgenerate

   assign w_run_press  = w_press[c_btn_run];
   assign w_step_press = w_press[c_btn_step];
   assign w_stop_press = w_press[c_btn_stop];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Priority: halt_in over every press, then stop > step > run.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_stop_press) begin
               w_next_state = IDLE;
            end else if (w_step_press) begin
               w_next_state = STEP;
            end else if (w_run_press) begin
               w_next_state = RUN;
            end
         end
         RUN: begin
            if (halt_in) begin
               w_next_state = HALT;
            end else if (w_stop_press) begin
               w_next_state = IDLE;
            end
         end
         STEP: begin
            if (halt_in) begin
               w_next_state = HALT;
            end else if (instr_done || w_stop_press) begin
               w_next_state = IDLE;
            end
         end
         HALT: begin
            if (w_stop_press) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Decoded straight from the state register so an async reset drops it at once.
   assign cpu_en  = (r_state == RUN) || (r_state == STEP);
   assign state_o = r_state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (instr_done && cpu_en) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_run_controller.sv
// +----------------------------------------------------------------+
// | tb_run_controller : randomized + directed bench with ref model |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module tb_run_controller;

   localparam int D  = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [2:0]    btn = 3'b000;   // {stop, step, run}
   logic          instr_done = 1'b0;
   logic          halt_in = 1'b0;
   logic          cpu_en;
   logic [1:0]    state_o;
   logic [CW-1:0] instr_count;

   int checks = 0;
   int failures = 0;

   run_controller #(
      .DEBOUNCE (D),
      .CNT_W    (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run_btn     (btn[0]),
      .step_btn    (btn[1]),
      .stop_btn    (btn[2]),
      .instr_done  (instr_done),
      .halt_in     (halt_in),
      .cpu_en      (cpu_en),
      .state_o     (state_o),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Mode: 0 idle, 1 run, 2 step, 3 halt. A button's filtered level flips
   // when the last D synchronized samples (raw delayed two edges) all differ.
   logic m_hist [3][8];
   bit   m_filt [3];
   bit   m_press[3];
   int   m_mode;
   int   m_count;

   task automatic model_clear();
      for (int b = 0; b < 3; b++) begin
         for (int j = 0; j < 8; j++) m_hist[b][j] = 1'b0;
         m_filt[b]  = 1'b0;
         m_press[b] = 1'b0;
      end
      m_mode  = 0;
      m_count = 0;
   endtask

   task automatic model_edge();
      bit run_p, step_p, stop_p, running, all_diff;
      run_p   = m_press[0];
      step_p  = m_press[1];
      stop_p  = m_press[2];
      running = (m_mode == 1) || (m_mode == 2);
      if (instr_done && running) m_count = (m_count + 1) % (1 << CW);
      if (m_mode == 0) begin
         if (stop_p)      m_mode = 0;
         else if (step_p) m_mode = 2;
         else if (run_p)  m_mode = 1;
      end else if (m_mode == 1) begin
         if (halt_in)     m_mode = 3;
         else if (stop_p) m_mode = 0;
      end else if (m_mode == 2) begin
         if (halt_in)                   m_mode = 3;
         else if (instr_done || stop_p) m_mode = 0;
      end else begin
         if (stop_p) m_mode = 0;
      end
      for (int b = 0; b < 3; b++) begin
         for (int j = 7; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
         m_hist[b][0] = btn[b];
         all_diff = 1'b1;
         for (int j = 2; j <= D + 1; j++)
            if (m_hist[b][j] == m_filt[b]) all_diff = 1'b0;
         m_press[b] = 1'b0;
         if (all_diff) begin
            m_filt[b]  = !m_filt[b];
            m_press[b] = m_filt[b];
         end
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_clear();
         else        model_edge();
      end
   end

   bit done = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (reset && !done) begin
            chk("model_state", {30'd0, state_o}, m_mode);
            chk("model_cpu_en", {31'd0, cpu_en}, {31'd0, (m_mode == 1) || (m_mode == 2)});
            chk("model_count", {28'd0, instr_count}, m_count);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic press(input int b, input int hold);
      btn[b] = 1'b1;
      tick(hold);
      btn[b] = 1'b0;
      tick(D + 3);
   endtask

   task automatic wait_state(input logic [1:0] exp, input int budget);
      int n = 0;
      while (state_o !== exp && n < budget) begin
         tick(1);
         n++;
      end
      if (state_o !== exp) begin
         checks++;
         failures++;
         $display("FAIL wait_state: got %0h expected %0h after %0d cycles", state_o, exp, budget);
      end
   endtask

   int hold[3];

   initial begin
      // Reset then run
      tick(2);
      chk("reset_state", {30'd0, state_o}, 32'h0);
      chk("reset_cpu_en", {31'd0, cpu_en}, 32'h0);
      chk("reset_count", {28'd0, instr_count}, 32'h0);
      reset = 1'b1;
      tick(1);
      btn[0] = 1'b1;
      @(posedge clk);                       // edge k: first sample of run_btn
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         chk("run_latency", {30'd0, state_o}, (i < 6) ? 32'h0 : 32'h1);
      end
      tick(3);
      btn[0] = 1'b0;
      tick(D + 4);
      chk("run_single_transition", {30'd0, state_o}, 32'h1);
      chk("run_cpu_en", {31'd0, cpu_en}, 32'h1);
      press(2, 6);
      chk("stop_to_idle", {30'd0, state_o}, 32'h0);

      // Glitch shorter than DEBOUNCE
      btn[1] = 1'b1;
      tick(3);
      btn[1] = 1'b0;
      tick(10);
      chk("glitch_idle", {30'd0, state_o}, 32'h0);

      // Single step
      btn[1] = 1'b1;
      wait_state(2'b10, 20);
      tick(4);
      instr_done = 1'b1;
      tick(1);
      instr_done = 1'b0;
      chk("step_back_idle", {30'd0, state_o}, 32'h0);
      chk("step_count", {28'd0, instr_count}, 32'h1);
      btn[1] = 1'b0;
      tick(D + 3);

      // Halt, ignored run, stop acknowledges
      press(0, 6);
      chk("halt_pre_run", {30'd0, state_o}, 32'h1);
      halt_in = 1'b1;
      tick(1);
      chk("halt_entry", {30'd0, state_o}, 32'h3);
      chk("halt_cpu_en", {31'd0, cpu_en}, 32'h0);
      press(0, 6);
      chk("halt_run_ignored", {30'd0, state_o}, 32'h3);
      press(2, 6);
      chk("halt_stop_idle", {30'd0, state_o}, 32'h0);
      tick(3);
      chk("halt_level_idle", {30'd0, state_o}, 32'h0);
      halt_in = 1'b0;

      // Simultaneous run + step
      btn[1:0] = 2'b11;
      wait_state(2'b10, 20);
      chk("simul_step", {30'd0, state_o}, 32'h2);
      btn[1:0] = 2'b00;
      tick(D + 3);
      instr_done = 1'b1;
      tick(1);
      instr_done = 1'b0;
      chk("simul_done_idle", {30'd0, state_o}, 32'h0);
      chk("simul_count", {28'd0, instr_count}, 32'h2);

      // Counter wrap then async reset mid-RUN
      press(0, 6);
      instr_done = 1'b1;
      tick(13);
      chk("wrap_15", {28'd0, instr_count}, 32'hF);
      tick(1);
      chk("wrap_0", {28'd0, instr_count}, 32'h0);
      instr_done = 1'b0;
      tick(1);
      chk("async_pre_cpu_en", {31'd0, cpu_en}, 32'h1);
      reset = 1'b0;
      #1;
      chk("async_cpu_en", {31'd0, cpu_en}, 32'h0);
      chk("async_count", {28'd0, instr_count}, 32'h0);
      chk("async_state", {30'd0, state_o}, 32'h0);
      tick(1);
      reset = 1'b1;
      tick(1);

      // Randomized traffic checked against the model every cycle
      for (int b = 0; b < 3; b++) hold[b] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int b = 0; b < 3; b++) begin
            if (hold[b] == 0) begin
               btn[b]  = 1'($urandom_range(0, 1));
               hold[b] = $urandom_range(1, 10);
            end else begin
               hold[b]--;
            end
         end
         instr_done = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) halt_in = ~halt_in;
         tick(1);
      end

      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
